// File: rtl/line_buf_ctrl.sv
// Line-buffer controller: counts ingress pixels into image coordinates, drives the
// shared line-BRAM address/write strobe and flags when a full sliding window is held.
module line_buf_ctrl #(
  parameter int LINE_W = 1920,
  parameter int WIN_W  = 45,
  parameter int WIN_H  = 5,
  parameter int IMG_H  = 1080,
  parameter int AW     = 11
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [7:0]    s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic          s_tlast,
  output logic          shift_en,
  output logic [AW-1:0] bram_addr,
  output logic          bram_we,
  output logic [7:0]    pix_out,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [10:0]   win_row,
  output logic [10:0]   win_col,
  output logic          busy,
  output logic          frame_done,
  output logic          err_line
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  localparam logic [10:0]   LAST_COL  = 11'(LINE_W - 1);
  localparam logic [10:0]   LAST_ROW  = 11'(IMG_H - 1);
  localparam logic [10:0]   WIN_COL0  = 11'(WIN_W - 1);
  localparam logic [10:0]   WIN_ROW0  = 11'(WIN_H - 1);
  localparam logic [AW-1:0] ADDR_WRAP = AW'(LINE_W - WIN_W - 1);

  state_t        state_q, state_d;
  logic [10:0]   row_q, row_d;
  logic [10:0]   col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wv_q, wv_d;
  logic [10:0]   wrow_q, wrow_d;
  logic [10:0]   wcol_q, wcol_d;
  logic          busy_q, busy_d;
  logic          fdone_q, fdone_d;
  logic          err_q, err_d;
  logic          accept;

  // A pending window that the consumer has not taken blocks ingress.
  assign s_tready = ((state_q == FILL) || (state_q == STREAM)) && !(wv_q && !win_ready);
  assign accept   = s_tvalid && s_tready;
  assign shift_en = accept;
  assign bram_we  = accept;
  assign pix_out  = s_tdata;

  assign bram_addr  = addr_q;
  assign win_valid  = wv_q;
  assign win_row    = wrow_q;
  assign win_col    = wcol_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign err_line   = err_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    wv_d    = wv_q;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;
    err_d   = err_q;
    fdone_d = 1'b0;

    if (win_ready) wv_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
          err_d   = 1'b0;
        end
      end
      FILL: begin
        if (accept && (row_q == WIN_ROW0) && (col_q == '0)) state_d = STREAM;
      end
      STREAM: begin
        if (accept && (row_q == LAST_ROW) && (col_q == LAST_COL)) begin
          state_d = DONE;
          fdone_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      // An early tlast ends the line; the BRAM address keeps counting regardless.
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + 11'd1;
        if (!s_tlast) err_d = 1'b1;
      end else if (s_tlast) begin
        col_d = '0;
        row_d = row_q + 11'd1;
        err_d = 1'b1;
      end else begin
        col_d = col_q + 11'd1;
      end

      addr_d = (addr_q == ADDR_WRAP) ? '0 : addr_q + 1'b1;

      if ((col_q >= WIN_COL0) && (row_q >= WIN_ROW0)) begin
        wv_d   = 1'b1;
        wrow_d = row_q;
        wcol_d = col_q;
      end
    end

    busy_d = (state_d == FILL) || (state_d == STREAM);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      wv_q    <= 1'b0;
      wrow_q  <= '0;
      wcol_q  <= '0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      wv_q    <= wv_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl on a small 8x3 image with a 3x2 window.
module tb_line_buf_ctrl;

  localparam int LINE_W = 8;
  localparam int WIN_W  = 3;
  localparam int WIN_H  = 2;
  localparam int IMG_H  = 3;
  localparam int AW     = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [7:0]    s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic          shift_en;
  logic [AW-1:0] bram_addr;
  logic          bram_we;
  logic [7:0]    pix_out;
  logic          win_valid;
  logic          win_ready;
  logic [10:0]   win_row;
  logic [10:0]   win_col;
  logic          busy;
  logic          frame_done;
  logic          err_line;

  int checks   = 0;
  int failures = 0;

  line_buf_ctrl #(
    .LINE_W(LINE_W), .WIN_W(WIN_W), .WIN_H(WIN_H), .IMG_H(IMG_H), .AW(AW)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .shift_en(shift_en), .bram_addr(bram_addr), .bram_we(bram_we), .pix_out(pix_out),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
    .busy(busy), .frame_done(frame_done), .err_line(err_line)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; combinational checks follow 1ns later.
  task automatic drive(input logic v, input int d, input logic last);
    @(negedge CLK);
    s_tvalid = v;
    s_tdata  = 8'(d);
    s_tlast  = last;
    #1;
  endtask

  task automatic after_edge;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(bram_addr), 0);
    chk({tag, "_wv"},   32'(win_valid), 0);
    chk({tag, "_wrow"}, 32'(win_row), 0);
    chk({tag, "_wcol"}, 32'(win_col), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_fd"},   32'(frame_done), 0);
    chk({tag, "_err"},  32'(err_line), 0);
    chk({tag, "_rdy"},  32'(s_tready), 0);
    chk({tag, "_sh"},   32'(shift_en), 0);
    chk({tag, "_we"},   32'(bram_we), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int addr_tbl [12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
    int wins;
    int first_win;
    int r;
    int c;
    logic q;

    RST = 1'b1; start = 1'b0; s_tdata = '0; s_tvalid = 1'b1; s_tlast = 1'b0; win_ready = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    chk_all_zero("reset");
    @(negedge CLK);
    RST = 1'b0;
    s_tvalid = 1'b0;

    // Full frame, continuous valid, consumer always ready.
    pulse_start();
    wins = 0;
    first_win = 0;
    for (int n = 1; n <= 24; n++) begin
      drive(1'b1, n, (n % 8) == 0);
      chk("f1_shift", 32'(shift_en), 1);
      chk("f1_we", 32'(bram_we), 1);
      chk("f1_pix", 32'(pix_out), 32'(n));
      if (n <= 12) chk("f1_addr", 32'(bram_addr), 32'(addr_tbl[n-1]));
      after_edge();
      r = (n - 1) / 8;
      c = (n - 1) % 8;
      q = (r >= 1) && (c >= 2);
      chk("f1_wv", 32'(win_valid), 32'(q));
      if (q) begin
        chk("f1_wrow", 32'(win_row), 32'(r));
        chk("f1_wcol", 32'(win_col), 32'(c));
        wins++;
        if (first_win == 0) first_win = n;
      end
      chk("f1_fd", 32'(frame_done), (n == 24) ? 1 : 0);
      chk("f1_busy", 32'(busy), (n == 24) ? 0 : 1);
    end
    chk("f1_wins", 32'(wins), 12);
    chk("f1_first", 32'(first_win), 11);
    drive(1'b1, 99, 1'b0);
    chk("done_rdy", 32'(s_tready), 0);
    chk("done_sh", 32'(shift_en), 0);
    after_edge();
    chk("idle_fd", 32'(frame_done), 0);
    chk("idle_wv", 32'(win_valid), 0);
    drive(1'b1, 99, 1'b0);
    chk("idle_rdy", 32'(s_tready), 0);
    drive(1'b0, 0, 1'b0);

    // Backpressure: consumer not ready when the first window appears.
    win_ready = 1'b0;
    pulse_start();
    for (int n = 1; n <= 11; n++) begin
      drive(1'b1, n, n == 8);
      after_edge();
    end
    chk("bp_wv", 32'(win_valid), 1);
    chk("bp_wrow", 32'(win_row), 1);
    chk("bp_wcol", 32'(win_col), 2);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 12, 1'b0);
      chk("bp_rdy", 32'(s_tready), 0);
      chk("bp_sh", 32'(shift_en), 0);
      after_edge();
      chk("bp_hold_wv", 32'(win_valid), 1);
      chk("bp_hold_wrow", 32'(win_row), 1);
      chk("bp_hold_wcol", 32'(win_col), 2);
    end
    @(negedge CLK);
    win_ready = 1'b1;
    #1;
    chk("bp_resume_rdy", 32'(s_tready), 1);
    chk("bp_resume_sh", 32'(shift_en), 1);
    after_edge();
    chk("bp_new_wv", 32'(win_valid), 1);
    chk("bp_new_wcol", 32'(win_col), 3);
    @(negedge CLK);
    win_ready = 1'b0;
    s_tvalid = 1'b0;
    after_edge();
    chk("bp_one_wv", 32'(win_valid), 1);
    chk("bp_one_wcol", 32'(win_col), 3);
    @(negedge CLK);
    win_ready = 1'b1;
    after_edge();
    chk("bp_clear_wv", 32'(win_valid), 0);
    drive(1'b1, 13, 1'b0);
    chk("bp_13_sh", 32'(shift_en), 1);
    after_edge();
    chk("bp_13_wcol", 32'(win_col), 4);

    // Asynchronous reset mid-frame after 13 accepts.
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk_all_zero("abort");
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 50 + k, 1'b0);
      chk("nostart_rdy", 32'(s_tready), 0);
      chk("nostart_sh", 32'(shift_en), 0);
      after_edge();
      chk("nostart_busy", 32'(busy), 0);
      chk("nostart_fd", 32'(frame_done), 0);
    end
    drive(1'b0, 0, 1'b0);

    // Early tlast on the 5th pixel of line 0; start mid-frame must be ignored.
    pulse_start();
    for (int n = 1; n <= 5; n++) begin
      drive(1'b1, n, n == 5);
      chk("tl_addr", 32'(bram_addr), 32'(n - 1));
      after_edge();
    end
    chk("tl_err", 32'(err_line), 1);
    drive(1'b1, 6, 1'b0);
    chk("tl_addr6", 32'(bram_addr), 0);
    after_edge();
    chk("tl_wv6", 32'(win_valid), 0);
    drive(1'b1, 7, 1'b0);
    chk("tl_addr7", 32'(bram_addr), 1);
    after_edge();
    chk("tl_wv7", 32'(win_valid), 0);
    s_tvalid = 1'b0;
    pulse_start();
    drive(1'b1, 8, 1'b0);
    after_edge();
    chk("tl_wv8", 32'(win_valid), 1);
    chk("tl_wrow8", 32'(win_row), 1);
    chk("tl_wcol8", 32'(win_col), 2);
    chk("tl_err_sticky", 32'(err_line), 1);
    chk("tl_busy", 32'(busy), 1);
    drive(1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
